// File: rtl/ddr4_perf_pkg.sv
// Shared types and encodings for the DDR4 read performance master.
// Holds the FSM state enum, the AXI burst/response codes and the default widths.
package ddr4_perf_pkg;

    localparam int DEF_ID_WTH          = 4;
    localparam int DEF_ADDR_WTH        = 33;
    localparam int DEF_LEN_WTH         = 8;
    localparam int DEF_DATA_WTH        = 512;
    localparam int DEF_RESP_WTH        = 2;
    localparam int DEF_MAX_OUTSTANDING = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } perf_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ddr4_rd_perf_master.sv
// AXI read traffic generator: issues cmd_num_bursts INCR bursts from cmd_addr,
// bounds outstanding reads, and reports cycle/beat counts plus protocol errors.
module ddr4_rd_perf_master
    import ddr4_perf_pkg::*;
#(
    parameter int AXI_ID_WTH      = DEF_ID_WTH,
    parameter int AXI_ADDR_WTH    = DEF_ADDR_WTH,
    parameter int AXI_LEN_WTH     = DEF_LEN_WTH,
    parameter int AXI_DATA_WTH    = DEF_DATA_WTH,
    parameter int AXI_RESP_WTH    = DEF_RESP_WTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AXI_ADDR_WTH-1:0] cmd_addr,
    input  logic [15:0]             cmd_num_bursts,
    input  logic [AXI_LEN_WTH-1:0]  cmd_len,
    output logic [AXI_ID_WTH-1:0]   arid,
    output logic [AXI_ADDR_WTH-1:0] araddr,
    output logic [AXI_LEN_WTH-1:0]  arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [AXI_ID_WTH-1:0]   rid,
    input  logic [AXI_DATA_WTH-1:0] rdata,
    input  logic [AXI_RESP_WTH-1:0] rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             cycle_count,
    output logic [31:0]             beat_count,
    output logic                    err_last,
    output logic                    err_resp
);

    localparam int                    BYTES    = AXI_DATA_WTH / 8;
    localparam logic [2:0]            SIZE     = 3'($clog2(BYTES));
    localparam int                    OUT_WTH  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_WTH-1:0]    OUT_MAX  = OUT_WTH'(MAX_OUTSTANDING);

    perf_state_e             state, state_next;
    logic [AXI_LEN_WTH-1:0]  len_q;
    logic [AXI_LEN_WTH-1:0]  beat_idx;
    logic [15:0]             bursts_left, left_next;
    logic [OUT_WTH-1:0]      outstanding, out_next;
    logic [AXI_ADDR_WTH-1:0] burst_bytes;
    logic                    cmd_hs, ar_hs, r_hs, last_hs, can_issue;
    logic                    unused_rbus;

    // Read data and ID are only counted, never inspected.
    assign unused_rbus = ^{rid, rdata};

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rready    = (state == ISSUE) || (state == DRAIN);

    assign arid    = '0;
    assign arlen   = len_q;
    assign arsize  = busy ? SIZE : 3'd0;
    assign arburst = busy ? BURST_INCR : 2'b00;

    assign cmd_hs  = cmd_valid && cmd_ready;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign last_hs = r_hs && rlast;

    assign burst_bytes = (AXI_ADDR_WTH'(len_q) + AXI_ADDR_WTH'(1)) << SIZE;
    assign left_next   = bursts_left - 16'(ar_hs);
    assign can_issue   = (out_next < OUT_MAX);

    // A stray rlast with nothing outstanding must not wrap the counter.
    always_comb begin
        out_next = outstanding;
        if (ar_hs && !last_hs)
            out_next = outstanding + OUT_WTH'(1);
        else if (!ar_hs && last_hs && (outstanding != '0))
            out_next = outstanding - OUT_WTH'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_hs) state_next = (cmd_num_bursts == 16'd0) ? DONE : ISSUE;
            ISSUE:   if (ar_hs && (bursts_left == 16'd1)) state_next = DRAIN;
            DRAIN:   if (out_next == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            outstanding <= '0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            len_q       <= '0;
            bursts_left <= '0;
            beat_idx    <= '0;
            done        <= 1'b0;
            cycle_count <= '0;
            beat_count  <= '0;
            err_last    <= 1'b0;
            err_resp    <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= out_next;
            done        <= (state == DONE);
            if (cmd_hs) begin
                araddr      <= cmd_addr;
                len_q       <= cmd_len;
                bursts_left <= cmd_num_bursts;
                arvalid     <= (cmd_num_bursts != 16'd0);
                beat_idx    <= '0;
                cycle_count <= '0;
                beat_count  <= '0;
                err_last    <= 1'b0;
                err_resp    <= 1'b0;
            end else begin
                if (ar_hs) begin
                    araddr      <= araddr + burst_bytes;
                    bursts_left <= left_next;
                end
                // Re-evaluate arvalid only when no address is pending, so a
                // presented address holds until it is accepted.
                if ((state == ISSUE) && (ar_hs || !arvalid))
                    arvalid <= (left_next != 16'd0) && can_issue;
                if (rready)
                    cycle_count <= sat_inc(cycle_count);
                if (r_hs) begin
                    beat_count <= sat_inc(beat_count);
                    beat_idx   <= rlast ? '0 : beat_idx + AXI_LEN_WTH'(1);
                    if (rlast != (beat_idx == len_q))
                        err_last <= 1'b1;
                    if (rresp != '0)
                        err_resp <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr4_rd_perf_master.sv
// Self-checking bench: reactive AXI read slave, address scoreboard and
// per-scenario tasks for the read performance master.
module tb_ddr4_rd_perf_master;
    import ddr4_perf_pkg::*;

    localparam int IDW = 4, AW = 33, LW = 8, DW = 512, RW = 2, MO = 8;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_num_bursts;
    logic [LW-1:0] cmd_len;
    logic [IDW-1:0] arid, rid;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [RW-1:0] rresp;
    logic          rlast, rvalid, rready;
    logic          busy, done, err_last, err_resp;
    logic [31:0]   cycle_count, beat_count;

    ddr4_rd_perf_master #(
        .AXI_ID_WTH(IDW), .AXI_ADDR_WTH(AW), .AXI_LEN_WTH(LW),
        .AXI_DATA_WTH(DW), .AXI_RESP_WTH(RW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_num_bursts(cmd_num_bursts), .cmd_len(cmd_len),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .busy(busy), .done(done), .cycle_count(cycle_count),
        .beat_count(beat_count), .err_last(err_last), .err_resp(err_resp)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    logic [AW-1:0] exp_addr_q[$];
    int ar_cnt = 0, done_cnt = 0, rr_cyc = 0;

    // slave controls, written only by the main initial block
    bit r_en = 1'b1;
    bit ar_rand = 1'b0;
    int early_last = -1;
    int bad_resp_beat = -1;

    // slave state
    int lens[$];
    int beat = 0;
    int beat_total = 0;

    // values seen mid-cycle, i.e. what the next rising edge will act on
    bit            rst_s, ar_fire_s, r_fire_s, rlast_s;
    logic [LW-1:0] arlen_s;
    bit            prev_pend = 1'b0;
    logic [AW-1:0] prev_addr;

    always @(negedge clk) begin
        rst_s     = rst;
        ar_fire_s = arvalid && arready;
        r_fire_s  = rvalid && rready;
        rlast_s   = rlast;
        arlen_s   = arlen;
        if (!rst) begin
            if (prev_pend) begin
                vec++;
                if (!(arvalid === 1'b1 && araddr === prev_addr)) begin
                    bad++;
                    $display("FAIL ar_hold: arvalid=%b araddr=%h, required arvalid=1 araddr=%h",
                             arvalid, araddr, prev_addr);
                end
            end
            if (arvalid && arready) begin
                ar_cnt++;
                vec++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL ar_unexpected: araddr=%h with no address expected", araddr);
                end else begin
                    logic [AW-1:0] e;
                    e = exp_addr_q.pop_front();
                    if (araddr !== e || arid !== '0 || arsize !== 3'd6 || arburst !== BURST_INCR) begin
                        bad++;
                        $display("FAIL ar_fields: addr=%h id=%0d size=%0d burst=%0d, required addr=%h id=0 size=6 burst=1",
                                 araddr, arid, arsize, arburst, e);
                    end
                end
            end
            if (arvalid && dut.outstanding == MO) begin
                vec++;
                bad++;
                $display("FAIL ar_cap: arvalid=1 with outstanding=%0d, required arvalid=0", dut.outstanding);
            end
            if (done) done_cnt++;
            if (rready) rr_cyc++;
        end
        prev_pend = !rst && arvalid && !arready;
        prev_addr = araddr;
    end

    // Reactive AXI read slave: one queued burst per accepted address.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; rdata = '0; rid = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_s) begin
                lens.delete();
                beat = 0;
            end else begin
                if (ar_fire_s) lens.push_back(int'(arlen_s));
                if (r_fire_s) begin
                    beat_total++;
                    if (rlast_s) begin
                        if (lens.size() > 0) void'(lens.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_en && lens.size() > 0) begin
                rvalid = 1'b1;
                rlast  = (early_last >= 0) ? (beat == early_last) : (beat == lens[0]);
                rresp  = (beat_total == bad_resp_beat) ? 2'b10 : 2'b00;
                rdata  = DW'(beat_total);
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = '0;
            end
        end
    end

    // Offers one command, queues its expected addresses, waits for done.
    // cyc = rising edges after the handshake edge until done is seen.
    task automatic run_cmd(input logic [AW-1:0] a, input int nb, input int len,
                           input int budget, output int cyc);
        int n;
        for (int i = 0; i < nb; i++)
            exp_addr_q.push_back(a + AW'(i * (len + 1) * BYTES));
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_num_bursts = 16'(nb); cmd_len = LW'(len);
        n = 0;
        while (!cmd_ready && n < budget) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < budget) begin @(posedge clk); #1; cyc++; end
        if (!done) begin
            vec++; bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_num_bursts = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({cmd_ready, busy, arvalid, rready, done, err_last, err_resp} !== 7'b1000000 ||
            araddr !== '0 || cycle_count !== 32'd0 || beat_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b busy=%b arv=%b rr=%b done=%b el=%b er=%b addr=%h cyc=%0d beats=%0d, required rdy=1 rest 0",
                     cmd_ready, busy, arvalid, rready, done, err_last, err_resp, araddr, cycle_count, beat_count);
        end
    endtask

    task automatic test_basic();
        int cyc, d0, r0, a0;
        d0 = done_cnt; r0 = rr_cyc; a0 = ar_cnt;
        run_cmd(33'h1000, 4, 7, 500, cyc);
        vec++;
        if (beat_count !== 32'd32 || err_last !== 1'b0 || err_resp !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: beats=%0d el=%b er=%b, required beats=32 el=0 er=0",
                     beat_count, err_last, err_resp);
        end
        vec++;
        if (cycle_count !== 32'(rr_cyc - r0)) begin
            bad++;
            $display("FAIL basic_cycles: cycle_count=%0d, required %0d", cycle_count, rr_cyc - r0);
        end
        repeat (4) @(posedge clk);
        #1;
        vec++;
        if (done_cnt - d0 != 1 || ar_cnt - a0 != 4 || exp_addr_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done pulses=%0d ar=%0d left=%0d busy=%b, required 1 4 0 0",
                     done_cnt - d0, ar_cnt - a0, exp_addr_q.size(), busy);
        end
    endtask

    task automatic test_zero_bursts();
        int cyc, a0;
        a0 = ar_cnt;
        run_cmd(33'h2000, 0, 3, 20, cyc);
        // done is in the second cycle after the handshake cycle
        vec++;
        if (cyc != 1) begin
            bad++;
            $display("FAIL zero_latency: done after %0d edges, required 1", cyc);
        end
        vec++;
        if (ar_cnt != a0 || cycle_count !== 32'd0 || beat_count !== 32'd0) begin
            bad++;
            $display("FAIL zero_result: ar=%0d cyc=%0d beats=%0d, required 0 0 0",
                     ar_cnt - a0, cycle_count, beat_count);
        end
    endtask

    task automatic test_outstanding_cap();
        int cyc, a0;
        a0 = ar_cnt;
        r_en = 1'b0;
        fork
            run_cmd(33'h4000, 20, 0, 400, cyc);
            begin
                repeat (40) @(posedge clk);
                #1;
                vec++;
                if (ar_cnt - a0 != MO || arvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL cap_stall: ar=%0d arvalid=%b, required %0d and 0", ar_cnt - a0, arvalid, MO);
                end
                r_en = 1'b1;
            end
        join
        vec++;
        if (ar_cnt - a0 != 20 || beat_count !== 32'd20 || err_last !== 1'b0) begin
            bad++;
            $display("FAIL cap_total: ar=%0d beats=%0d el=%b, required 20 20 0", ar_cnt - a0, beat_count, err_last);
        end
    endtask

    task automatic test_bad_last();
        int cyc;
        early_last = 2;
        run_cmd(33'h8000, 2, 3, 300, cyc);
        vec++;
        if (err_last !== 1'b1 || beat_count !== 32'd6) begin
            bad++;
            $display("FAIL last_err: el=%b beats=%0d, required 1 and 6", err_last, beat_count);
        end
        early_last = -1;
        @(posedge clk); #1;
        vec++;
        if (err_last !== 1'b1) begin
            bad++;
            $display("FAIL last_sticky: el=%b, required 1", err_last);
        end
        run_cmd(33'h9000, 1, 1, 300, cyc);
        vec++;
        if (err_last !== 1'b0 || beat_count !== 32'd2) begin
            bad++;
            $display("FAIL last_clear: el=%b beats=%0d, required 0 and 2", err_last, beat_count);
        end
    endtask

    task automatic test_bad_resp();
        int cyc;
        bad_resp_beat = beat_total + 5;
        run_cmd(33'hA000, 3, 3, 300, cyc);
        vec++;
        if (err_resp !== 1'b1 || err_last !== 1'b0 || beat_count !== 32'd12) begin
            bad++;
            $display("FAIL resp_err: er=%b el=%b beats=%0d, required 1 0 12", err_resp, err_last, beat_count);
        end
        bad_resp_beat = -1;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if (err_resp !== 1'b1) begin
            bad++;
            $display("FAIL resp_sticky: er=%b, required 1", err_resp);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, nb, len, r0;
        logic [AW-1:0] a;
        ar_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nb  = $urandom_range(1, 5);
            len = $urandom_range(0, 3);
            // first command straddles the top of the address space
            a   = (k == 0) ? 33'h1_FFFF_FF00 : AW'($urandom_range(0, 32'h00FF_FFFF)) << 6;
            r0  = rr_cyc;
            run_cmd(a, nb, len, 600, cyc);
            vec++;
            if (beat_count !== 32'(nb * (len + 1)) || err_last !== 1'b0 || err_resp !== 1'b0 ||
                cycle_count !== 32'(rr_cyc - r0)) begin
                bad++;
                $display("FAIL b2b_%0d: beats=%0d el=%b er=%b cyc=%0d, required beats=%0d 0 0 cyc=%0d",
                         k, beat_count, err_last, err_resp, cycle_count, nb * (len + 1), rr_cyc - r0);
            end
        end
        ar_rand = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n, d0;
        r_en = 1'b0;
        for (int i = 0; i < 10; i++)
            exp_addr_q.push_back(33'hC000 + AW'(i * 4 * BYTES));
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 33'hC000; cmd_num_bursts = 16'd10; cmd_len = 8'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (dut.outstanding != 3 && n < 50) begin @(posedge clk); #1; n++; end
        vec++;
        if (dut.outstanding != 3) begin
            bad++;
            $display("FAIL rst_setup: outstanding=%0d, required 3", dut.outstanding);
        end
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        vec++;
        if (busy !== 1'b0 || arvalid !== 1'b0 || dut.outstanding != 0 || cmd_ready !== 1'b1 ||
            araddr !== '0 || beat_count !== 32'd0 || cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b arv=%b out=%0d rdy=%b addr=%h beats=%0d cyc=%0d, required 0 0 0 1 0 0 0",
                     busy, arvalid, dut.outstanding, cmd_ready, araddr, beat_count, cycle_count);
        end
        rst = 1'b0;
        exp_addr_q.delete();
        r_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vec++;
        if (done_cnt != d0 || busy !== 1'b0 || arvalid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: done pulses=%0d busy=%b arv=%b, required 0 0 0", done_cnt - d0, busy, arvalid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_bursts();
        test_outstanding_cap();
        test_bad_last();
        test_bad_resp();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/ddr4_rd_perf_master.md
DDR4_RD_PERF_MASTER -- requirements
Module: ddr4_rd_perf_master

Interface
REQ-001 SHALL have parameter AXI_ID_WTH, default 4, ID width.
REQ-002 SHALL have parameter AXI_ADDR_WTH, default 33, byte address width.
REQ-003 SHALL have parameter AXI_LEN_WTH, default 8, burst length width.
REQ-004 SHALL have parameter AXI_DATA_WTH, default 512, data width in bits.
REQ-005 SHALL have parameter AXI_RESP_WTH, default 2, response width.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 8, read address handshakes allowed without rlast.
REQ-007 Ports, in this order:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  AXI_ADDR_WTH  start byte address.
- cmd_num_bursts  in  16  burst count.
- cmd_len  in  AXI_LEN_WTH  beats per burst minus 1.
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID/ADDR/LEN/3/2/1  AXI read address.
- arready  in  1  AXI read address ready.
- rid/rdata/rresp/rlast/rvalid  in  ID/DATA/RESP/1/1  AXI read data.
- rready  out  1  AXI read data ready.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- cycle_count  out  32  cycles of the last command.
- beat_count  out  32  beats received for the last command.
- err_last  out  1  sticky rlast-position error.
- err_resp  out  1  sticky non-OKAY rresp.

Function
REQ-008 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-009 cmd_ready SHALL be 1 only in IDLE; a handshake latches the command, clears both counters and both error flags, and moves to ISSUE, or to DONE if cmd_num_bursts == 0.
REQ-010 arvalid SHALL first assert the cycle after the command handshake.
REQ-011 arid SHALL be 0; arlen SHALL equal the latched cmd_len.
REQ-012 arsize SHALL equal log2(AXI_DATA_WTH/8); arburst SHALL be 2'b01 (INCR).
REQ-013 Once asserted, arvalid and araddr SHALL hold until arready is seen.
REQ-014 arvalid SHALL not assert while outstanding == MAX_OUTSTANDING.
REQ-015 After each AR handshake, araddr SHALL advance by (cmd_len+1)*(AXI_DATA_WTH/8), modulo 2^AXI_ADDR_WTH.
REQ-016 outstanding SHALL increment on an AR handshake and decrement on an rlast beat; both in one cycle leaves it unchanged.
REQ-017 ISSUE SHALL go to DRAIN on the AR handshake of the final burst.
REQ-018 DRAIN SHALL go to DONE on the cycle when outstanding reaches 0.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 rready SHALL be 1 in ISSUE and DRAIN and 0 otherwise.
REQ-021 beat_count SHALL increment on every rvalid&&rready beat.
REQ-022 err_last SHALL set if rlast is 1 on any beat other than beat cmd_len of a burst, or 0 on that beat.
REQ-023 err_resp SHALL set on any beat with rresp != 0.
REQ-024 cycle_count SHALL increment every cycle in ISSUE and DRAIN and freeze in DONE and IDLE.
REQ-025 busy SHALL be 1 outside IDLE.
REQ-026 Counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-027 rst SHALL force IDLE, outstanding=0, and all outputs to 0 (araddr=0, counters=0, flags=0), mid-burst included.
REQ-028 In-flight AXI transactions SHALL be abandoned on reset; the slave shares rst.

Structure
REQ-029 Package ddr4_perf_pkg SHALL hold the FSM state enum, the AXI burst/resp encodings and the default widths.
REQ-030 The block SHALL be one module with no sub-module; outstanding tracking is inline.

Verification
REQ-031 addr=0x1000, bursts=4, len=7, arready/rvalid always 1 -> araddr 0x1000,0x1200,0x1400,0x1600; beat_count=32; done once; no errors.
REQ-032 bursts=0 -> no arvalid; done pulses 2 cycles after the command handshake; cycle_count=0.
REQ-033 bursts=20, MAX_OUTSTANDING=8, rvalid held 0 -> exactly 8 AR handshakes, then arvalid stays 0 until rlast beats arrive.
REQ-034 len=3, slave drives rlast on beat 2 -> err_last=1, still drains and pulses done; next command clears err_last.
REQ-035 rresp=2'b10 on one beat -> err_resp=1 through done.
REQ-036 rst asserted with 3 bursts outstanding -> next cycle busy=0, arvalid=0, outstanding=0, cmd_ready=1.
